setpoint_sequencer: RTL and testbench
=====================================

// Module: setpoint_sequencer
// PURPOSE
//  Sits between the SPI roll-command receiver and the 16-bit PID loop: turns raw SPI frames into a rate-limited,
//  watchdog-guarded setpoint in the clk domain. Synchronises the SPI frame strobe (nss) into clk and captures each frame.
//  Ramps the setpoint toward the commanded target and gates the PID/motor on command freshness.
// PARAMETERS
//  WIDTH          16    setpoint/position/frame width (signed two's complement)
//  SYNC_STAGES    2     flops in the nss synchroniser (>=2)
//  TICK_DIV       6000  clk cycles per ramp/watchdog tick (1 kHz at 6 MHz clk)
//  MAX_STEP       16    max |setpoint change| per tick, encoder counts
//  TIMEOUT_TICKS  100   ticks without a frame before TIMEOUT
// PORTS
//  clk          in   1      system clock (HSOSC-derived)
//  rst_raw      in   1      reset, asynchronous, active-low
//  nss          in   1      SPI chip select, async to clk; rising edge = frame end
//  spi_word     in   WIDTH  SPI shift-register contents; sck domain, stable while nss high
//  position     in   WIDTH  signed encoder position from quadrature decoder
//  setpoint     out  WIDTH  signed setpoint to PID
//  pid_enable   out  1      1 = PID/PWM may drive motor; 0 = PID held in reset
//  fault        out  1      1 while in TIMEOUT
//  frame_cnt    out  8      accepted-frame counter, wraps 255->0
// BEHAVIOUR
//  Reset (rst_raw low, async): state=IDLE, setpoint=0, pid_enable=0, fault=0, frame_cnt=0, tick/watchdog counters=0.
//  Capture: nss synchronised through SYNC_STAGES flops; rising edge of synced nss produces frame_stb (1 cycle).
//   On frame_stb: target <= sat(position - spi_word) (17-bit diff, saturate to WIDTH); frame_cnt++; watchdog cleared.
//   Latency: nss rise -> frame_stb after SYNC_STAGES+1 clk; target valid the cycle after.
//  Tick: free-running counter 0..TICK_DIV-1; tick=1 for one cycle at wrap. Ramp and watchdog advance only on tick.
//  Ramp (on tick, RAMP state): diff=target-setpoint (WIDTH+1 bits); |diff|<=MAX_STEP -> setpoint=target,
//   else setpoint += sign(diff)*MAX_STEP. Never overshoots.
//  States:
//   IDLE    : setpoint tracks position every cycle; pid_enable=0. frame_stb -> RAMP.
//   RAMP    : pid_enable=1; ramp on tick; setpoint==target -> HOLD.
//   HOLD    : pid_enable=1; setpoint fixed. frame_stb with new target != setpoint -> RAMP.
//   TIMEOUT : entered from RAMP/HOLD when watchdog reaches TIMEOUT_TICKS; pid_enable=0, fault=1,
//             setpoint tracks position every cycle. frame_stb -> RAMP (fault clears same cycle).
//  Watchdog: counts ticks in RAMP/HOLD, cleared on frame_stb; not counted in IDLE/TIMEOUT.
//  Simultaneous frame_stb and tick: frame wins - target/watchdog updated, no ramp step that cycle.
//  Simultaneous frame_stb and watchdog expiry: frame wins, no TIMEOUT entry.
//  Frame whose target equals current setpoint in HOLD: stay HOLD, watchdog still cleared.
//  nss glitch shorter than one clk may be missed; no partial-frame detection (receiver responsibility).
//  Reset mid-ramp: outputs return to reset values immediately; first post-reset frame restarts from position.
// STRUCTURE
//  motor_ctrl_pkg: seq_state_t enum {IDLE,RAMP,HOLD,TIMEOUT}; WIDTH default; function sat_add(a,b) -> WIDTH signed.
//  Sub-module sync_rise_detect #(STAGES): async input synchroniser + rising-edge pulse; instanced once for nss.
//  Remainder (tick divider, watchdog, FSM, ramp adder) flat in setpoint_sequencer.
// TESTING (TICK_DIV=10, TIMEOUT_TICKS=5, MAX_STEP=16 in bench)
//  Reset held, toggle nss -> all outputs 0, frame_cnt stays 0; release -> IDLE, setpoint follows position=123.
//  position=100, spi_word=-50, nss rise -> frame_stb at +3 clk, target=150, RAMP, setpoint 100->116->132->148->150, HOLD.
//  position=32760, spi_word=-100 -> target saturates to 32767; spi_word=32767 at position=-10 -> target -32768.
//  No frames for 5 ticks in HOLD -> TIMEOUT, fault=1, pid_enable=0, setpoint==position; next frame -> RAMP, fault=0.
//  nss rise aligned so frame_stb coincides with tick -> no step that tick, watchdog=0, next tick steps toward new target.
//  rst_raw low mid-RAMP (async, between clk edges) -> outputs zero before next clk edge; 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor-control setpoint path.
package motor_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    HOLD    = 2'd2,
    TIMEOUT = 2'd3
  } seq_state_t;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int unsigned w);
    int hi;
    int lo;
    int sum;
    hi  = (1 <<< (w - 1)) - 1;
    lo  = -(1 <<< (w - 1));
    sum = a + b;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchroniser for an asynchronous level plus a registered
// one-cycle pulse on its rising edge.
module sync_rise_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_raw,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Chain resets to the idle-high level of chip select so reset release
  // with the line idle never looks like a frame end.
  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      sync_q <= '1;
      last_q <= 1'b1;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/setpoint_sequencer.sv
// Turns captured SPI frames into a rate-limited, watchdog-guarded setpoint
// for the PID loop.
module setpoint_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TICK_DIV      = 6000,
  parameter int unsigned MAX_STEP      = 16,
  parameter int unsigned TIMEOUT_TICKS = 100
) (
  input  logic                    clk,
  input  logic                    rst_raw,
  input  logic                    nss,
  input  logic signed [WIDTH-1:0] spi_word,
  input  logic signed [WIDTH-1:0] position,
  output logic signed [WIDTH-1:0] setpoint,
  output logic                    pid_enable,
  output logic                    fault,
  output logic [7:0]              frame_cnt
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic signed [WIDTH:0]   STEP_D = (WIDTH+1)'(MAX_STEP);
  localparam logic signed [WIDTH-1:0] STEP_N = WIDTH'(MAX_STEP);

  seq_state_t              state;
  seq_state_t              state_nxt;
  logic                    frame_stb;
  logic                    tick;
  logic [TICK_W-1:0]       tick_cnt;
  logic [WD_W-1:0]         wd_cnt;
  logic [WD_W-1:0]         wd_nxt;
  logic signed [WIDTH-1:0] target;
  logic signed [WIDTH-1:0] target_c;
  logic signed [WIDTH-1:0] ramp_c;
  logic signed [WIDTH-1:0] setpoint_nxt;
  logic signed [WIDTH:0]   diff_c;

  sync_rise_detect #(
    .STAGES (SYNC_STAGES)
  ) u_nss_sync (
    .clk     (clk),
    .rst_raw (rst_raw),
    .din     (nss),
    .rise    (frame_stb)
  );

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running ramp/watchdog time base.
  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Commanded target (position minus frame word, saturated) and one ramp step toward it.
  always_comb begin
    target_c = WIDTH'(sat_add(int'(position), -int'(spi_word), WIDTH));
    diff_c   = $signed({target[WIDTH-1], target}) - $signed({setpoint[WIDTH-1], setpoint});
    if (diff_c > STEP_D) begin
      ramp_c = setpoint + STEP_N;
    end else if (diff_c < -STEP_D) begin
      ramp_c = setpoint - STEP_N;
    end else begin
      ramp_c = target;
    end
  end

  // Next state, next setpoint and watchdog; a frame always beats a coincident tick.
  always_comb begin
    state_nxt    = state;
    setpoint_nxt = setpoint;
    wd_nxt       = wd_cnt;
    case (state)
      IDLE, TIMEOUT: begin
        setpoint_nxt = position;
        if (frame_stb) begin
          state_nxt = RAMP;
          wd_nxt    = '0;
        end
      end
      RAMP, HOLD: begin
        if (frame_stb) begin
          wd_nxt = '0;
          if ((state == RAMP) || (target_c != setpoint)) begin
            state_nxt = RAMP;
          end else begin
            state_nxt = HOLD;
          end
        end else if (tick) begin
          if (state == RAMP) begin
            setpoint_nxt = ramp_c;
          end
          if (wd_cnt == WD_W'(TIMEOUT_TICKS - 1)) begin
            state_nxt    = TIMEOUT;
            wd_nxt       = '0;
            setpoint_nxt = position;
          end else begin
            wd_nxt = wd_cnt + WD_W'(1);
            if ((state == RAMP) && (ramp_c == target)) begin
              state_nxt = HOLD;
            end
          end
        end else if ((state == RAMP) && (setpoint == target)) begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered datapath and outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      setpoint   <= '0;
      target     <= '0;
      wd_cnt     <= '0;
      frame_cnt  <= '0;
      pid_enable <= 1'b0;
      fault      <= 1'b0;
    end else begin
      setpoint   <= setpoint_nxt;
      wd_cnt     <= wd_nxt;
      pid_enable <= (state_nxt == RAMP) || (state_nxt == HOLD);
      fault      <= (state_nxt == TIMEOUT);
      if (frame_stb) begin
        target    <= target_c;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_setpoint_sequencer.sv
// Scoreboard bench for setpoint_sequencer: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT outputs move.
module tb_setpoint_sequencer;

  localparam int unsigned W = 16;
  localparam int TICK = 10;
  localparam int TMO  = 5;
  localparam int STEP = 16;
  localparam int SYNC = 2;

  logic                clk = 1'b0;
  logic                rst_raw;
  logic                nss;
  logic signed [W-1:0] spi_word;
  logic signed [W-1:0] position;
  logic signed [W-1:0] setpoint;
  logic                pid_enable;
  logic                fault;
  logic [7:0]          frame_cnt;

  setpoint_sequencer #(
    .WIDTH         (W),
    .SYNC_STAGES   (SYNC),
    .TICK_DIV      (TICK),
    .MAX_STEP      (STEP),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk        (clk),
    .rst_raw    (rst_raw),
    .nss        (nss),
    .spi_word   (spi_word),
    .position   (position),
    .setpoint   (setpoint),
    .pid_enable (pid_enable),
    .fault      (fault),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int cyc;
  } frame_exp_t;

  frame_exp_t cnt_q[$];
  int sp_q[$];
  int en_q[$];
  int fault_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  int m_cnt = 0;
  int m_sp = 0;
  bit m_en = 1'b0;
  bit mon_en = 1'b0;

  int prev_cnt = 0;
  int prev_sp = 0;
  bit prev_en = 1'b0;
  bit prev_fault = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int limit_step(input int d);
    if (d > STEP) return STEP;
    if (d < -STEP) return -STEP;
    return d;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI frame: chip select low, load word, release; optional tick-phase alignment of the rise.
  task automatic send_frame(input int pos, input int word, input int phase, input bit track);
    int tgt;
    position = W'(pos);
    spi_word = W'(word);
    nss = 1'b0;
    step(2);
    if (phase >= 0) begin
      while (((cyc - base) % TICK) != phase) step(1);
    end
    nss = 1'b1;
    m_cnt = (m_cnt + 1) % 256;
    cnt_q.push_back('{cnt: m_cnt, cyc: cyc});
    tgt = sat16(pos - word);
    if (!m_en) begin
      en_q.push_back(pos);
      m_sp = pos;
      m_en = 1'b1;
    end
    if (track) begin
      while (m_sp != tgt) begin
        m_sp = m_sp + limit_step(tgt - m_sp);
        sp_q.push_back(m_sp);
      end
    end
  endtask

  task automatic expect_timeout(input int pos);
    fault_q.push_back(pos);
    step(70);
    m_en = 1'b0;
  endtask

  // Monitor: compare each visible output event against the head of its queue.
  always @(negedge clk) begin
    frame_exp_t fe;
    if (mon_en && rst_raw) begin
      if (int'(frame_cnt) != prev_cnt) begin
        if (cnt_q.size() == 0) begin
          chk("frame_unexpected", int'(frame_cnt), prev_cnt);
        end else begin
          fe = cnt_q.pop_front();
          chk("frame_cnt", int'(frame_cnt), fe.cnt);
          chk("frame_latency", cyc - fe.cyc, SYNC + 2);
        end
      end
      if (pid_enable && !prev_en) begin
        if (en_q.size() == 0) chk("enable_unexpected", int'(pid_enable), int'(prev_en));
        else chk("enable_start_sp", int'(setpoint), en_q.pop_front());
      end else if (pid_enable && prev_en && (int'(setpoint) != prev_sp)) begin
        if (sp_q.size() == 0) chk("ramp_unexpected", int'(setpoint), prev_sp);
        else chk("ramp_step", int'(setpoint), sp_q.pop_front());
      end
      if (fault && !prev_fault) begin
        if (fault_q.size() == 0) begin
          chk("fault_unexpected", int'(fault), int'(prev_fault));
        end else begin
          chk("fault_sp_tracks", int'(setpoint), fault_q.pop_front());
          chk("fault_pid_off", int'(pid_enable), 0);
        end
      end
      if (!fault && prev_fault) chk("fault_clear_pid_on", int'(pid_enable), 1);
    end
    prev_cnt   = int'(frame_cnt);
    prev_sp    = int'(setpoint);
    prev_en    = pid_enable;
    prev_fault = fault;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: run did not complete, errors=%0d", errors);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int pos;
    int word;
    int tgt;
    int c2;
    rst_raw  = 1'b0;
    nss      = 1'b1;
    position = '0;
    spi_word = '0;
    step(3);

    // Frames under reset must be ignored.
    position = 123;
    for (int i = 0; i < 4; i++) begin
      nss = ~nss;
      spi_word = W'(i * 7);
      step(2);
    end
    chk("rst_setpoint", int'(setpoint), 0);
    chk("rst_pid_enable", int'(pid_enable), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);

    rst_raw = 1'b1;
    base = cyc;
    mon_en = 1'b1;
    step(1);
    chk("idle_track_123", int'(setpoint), 123);
    chk("idle_pid_off", int'(pid_enable), 0);
    position = -77;
    step(1);
    chk("idle_track_neg", int'(setpoint), -77);

    // Basic ramp 100 -> 150, then five silent ticks into TIMEOUT.
    send_frame(100, -50, -1, 1'b1);
    expect_timeout(100);
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_pid_off", int'(pid_enable), 0);
    position = 555;
    step(1);
    chk("timeout_track", int'(setpoint), 555);

    // Recovery from TIMEOUT: fault clears on frame acceptance.
    send_frame(555, 5, -1, 1'b1);
    step(3);
    chk("recover_fault_before", int'(fault), 1);
    step(1);
    chk("recover_fault_clear", int'(fault), 0);
    chk("recover_pid_on", int'(pid_enable), 1);
    expect_timeout(555);

    // Saturation at both ends of the range.
    send_frame(32760, -100, -1, 1'b1);
    expect_timeout(32760);
    send_frame(-10, 32767, -1, 1'b0);
    sp_q.push_back(-26);
    sp_q.push_back(-42);
    sp_q.push_back(-58);
    sp_q.push_back(-74);
    expect_timeout(-10);

    // Frame strobe landing on a tick: no step that tick, watchdog restarts.
    position = 1000;
    step(2);
    send_frame(1000, -200, 8, 1'b0);
    sp_q.push_back(1016);
    m_sp = 1016;
    step(8);
    send_frame(1000, 40, 6, 1'b1);
    c2 = cyc;
    fault_q.push_back(1000);
    step(13);
    chk("align_no_step", int'(setpoint), 1016);
    step(1);
    chk("align_next_tick_step", int'(setpoint), 1000);
    step(39);
    chk("align_wd_before", int'(fault), 0);
    step(1);
    chk("align_wd_expire", int'(fault), 1);
    if ((cyc - c2) != 54) chk("align_timing", cyc - c2, 54);
    m_en = 1'b0;
    step(5);

    // Randomized commands with periodic keep-alive frames and occasional timeouts.
    pos = 0;
    for (int n = 0; n < 10; n++) begin
      pos  = int'($urandom_range(20000)) - 10000;
      tgt  = (m_en ? m_sp : pos) + int'($urandom_range(300)) - 150;
      word = pos - tgt;
      send_frame(pos, word, -1, 1'b1);
      for (int r = 0; r < 6; r++) begin
        step(20);
        send_frame(pos, word, -1, 1'b1);
      end
      step(3);
      if ($urandom_range(2) == 0) expect_timeout(pos);
    end
    if (m_en) expect_timeout(pos);

    // Asynchronous reset in the middle of a ramp.
    send_frame(2000, -1000, -1, 1'b0);
    step(5);
    mon_en = 1'b0;
    step(25);
    chk("midramp_moved", int'(setpoint > 16'sd2000), 1);
    @(posedge clk);
    #2;
    rst_raw = 1'b0;
    #1;
    chk("async_rst_setpoint", int'(setpoint), 0);
    chk("async_rst_pid", int'(pid_enable), 0);
    chk("async_rst_fault", int'(fault), 0);
    chk("async_rst_cnt", int'(frame_cnt), 0);
    step(3);
    rst_raw = 1'b1;
    base = cyc;
    m_cnt = 0;
    m_en = 1'b0;
    mon_en = 1'b1;
    step(2);

    // 256 frames after reset: restart from position and wrap the counter.
    for (int f = 0; f < 256; f++) begin
      send_frame(-300, 0, -1, 1'b1);
      step(3);
    end
    step(5);
    chk("cnt_wrap", int'(frame_cnt), 0);
    chk("wrap_pid_on", int'(pid_enable), 1);
    chk("wrap_setpoint", int'(setpoint), -300);

    step(10);
    chk("cnt_q_drained", cnt_q.size(), 0);
    chk("sp_q_drained", sp_q.size(), 0);
    chk("en_q_drained", en_q.size(), 0);
    chk("fault_q_drained", fault_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
